// File: rtl/sprite_bus_pkg.sv
// Shared sprite bus definitions: command word layout, control codes and the
// scheduler state type. Imported by the scheduler and every *_display component.
package sprite_bus_pkg;

    localparam int unsigned CMD_W       = 32;
    localparam int unsigned COMP_ID_LSB = 26;
    localparam int unsigned CHILD_LSB   = 21;
    localparam int unsigned CTRL_LSB    = 17;
    localparam int unsigned DTYPE_LSB   = 14;
    localparam int unsigned BUF_BIT     = 13;
    localparam int unsigned MSG_LSB     = 0;

    localparam logic [3:0] CTRL_NOP    = 4'h0;
    localparam logic [3:0] CTRL_UPDATE = 4'h1;
    localparam logic [3:0] CTRL_SWAP   = 4'hF;

    typedef struct packed {
        logic [5:0]  comp_id;
        logic [4:0]  child;
        logic [3:0]  ctrl;
        logic [2:0]  dtype;
        logic        buf_sel;
        logic [12:0] msg;
    } sprite_cmd_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GAP     = 2'd1,
        WAIT_VB = 2'd2,
        SWAP    = 2'd3
    } sched_state_t;

    // Broadcast word that flips every component to buffer buf_sel.
    function automatic logic [CMD_W-1:0] swap_word(input logic buf_sel);
        sprite_cmd_t w;
        w         = '0;
        w.ctrl    = CTRL_SWAP;
        w.buf_sel = buf_sel;
        return w;
    endfunction

endpackage

// File: rtl/sprite_cmd_scheduler_cmd_fifo.sv
// cmd_fifo: synchronous FIFO with first-word-fall-through head.
// Ports: clk, reset (async, active-high), i_push/i_data write side,
//        i_pop/o_head read side, o_full/o_empty status from the registered count.
module cmd_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == CW'(0));
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    // Storage needs no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sprite_cmd_scheduler.sv
// sprite_cmd_scheduler: queues CPU sprite commands, stamps them with the back
// buffer index and broadcasts them one per two cycles; a commit word holds the
// queue until vblank, then broadcasts a swap word flipping every component.
// Ports: clk, reset; cmd_data/cmd_valid/cmd_ready command input; hcount/vcount
//        raster position; writedata broadcast bus; active_buf, frame_pending,
//        overflow status.
module sprite_cmd_scheduler
    import sprite_bus_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter logic [9:0]  VBLANK_LINE = 10'd480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    output logic [31:0] writedata,
    output logic        active_buf,
    output logic        frame_pending,
    output logic        overflow
);

    sched_state_t r_state;
    sched_state_t w_state_nxt;
    logic [31:0]  w_wd_nxt;
    logic         w_buf_nxt;
    logic         w_pend_nxt;
    logic         w_pop;
    logic         w_push;
    logic         w_full;
    logic         w_empty;
    logic [31:0]  w_head_raw;
    sprite_cmd_t  w_head;
    sprite_cmd_t  w_issue;
    logic         w_vb_hit;
    logic         r_vb_hit_q;
    logic         w_vb_trig;

    assign cmd_ready = ~w_full;
    assign w_push    = cmd_valid & cmd_ready;
    assign w_head    = sprite_cmd_t'(w_head_raw);

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (cmd_data),
        .i_pop   (w_pop),
        .o_head  (w_head_raw),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Edge-detect the vblank point so a slow pixel clock yields one trigger.
    assign w_vb_hit  = (vcount == VBLANK_LINE) && (hcount == 10'd0);
    assign w_vb_trig = w_vb_hit & ~r_vb_hit_q;

    // Head word with its buffer bit forced to the back buffer.
    always_comb begin
        w_issue         = w_head;
        w_issue.buf_sel = ~active_buf;
    end

    // Next-state and next-output logic; the bus idles at zero unless issuing.
    always_comb begin
        w_state_nxt = r_state;
        w_wd_nxt    = '0;
        w_buf_nxt   = active_buf;
        w_pend_nxt  = frame_pending;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    case (w_head.ctrl)
                        CTRL_NOP: w_state_nxt = IDLE;
                        CTRL_SWAP: begin
                            w_pend_nxt  = 1'b1;
                            w_state_nxt = WAIT_VB;
                        end
                        default: begin
                            w_wd_nxt    = w_issue;
                            w_state_nxt = GAP;
                        end
                    endcase
                end
            end
            GAP: w_state_nxt = IDLE;
            WAIT_VB: begin
                // Swap word is registered on the trigger so it lands one cycle later.
                if (w_vb_trig) begin
                    w_wd_nxt    = swap_word(~active_buf);
                    w_buf_nxt   = ~active_buf;
                    w_pend_nxt  = 1'b0;
                    w_state_nxt = SWAP;
                end
            end
            SWAP:    w_state_nxt = GAP;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            writedata     <= '0;
            active_buf    <= 1'b0;
            frame_pending <= 1'b0;
            overflow      <= 1'b0;
            r_vb_hit_q    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            writedata     <= w_wd_nxt;
            active_buf    <= w_buf_nxt;
            frame_pending <= w_pend_nxt;
            overflow      <= overflow | (cmd_valid & ~cmd_ready);
            r_vb_hit_q    <= w_vb_hit;
        end
    end

endmodule

// File: tb/tb_sprite_cmd_scheduler.sv
// Self-checking bench for sprite_cmd_scheduler: directed scenarios followed by
// randomized batches compared against an ordered-word reference model.
module tb_sprite_cmd_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [31:0] writedata;
    logic        active_buf;
    logic        frame_pending;
    logic        overflow;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] seen[$];
    logic [31:0] expq[$];
    logic        m_buf;

    localparam logic [31:0] COMMIT = 32'h001E_0000;

    sprite_cmd_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_data      (cmd_data),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .hcount        (hcount),
        .vcount        (vcount),
        .writedata     (writedata),
        .active_buf    (active_buf),
        .frame_pending (frame_pending),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    // Record every non-idle bus word in order.
    always @(negedge clk) begin
        if (writedata !== 32'h0) seen.push_back(writedata);
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Word as the components should see it: buffer bit is the back buffer.
    function automatic logic [31:0] stamp(input logic [31:0] w, input logic cur);
        logic [31:0] r;
        r     = w;
        r[13] = ~cur;
        return r;
    endfunction

    function automatic logic [31:0] swapw(input logic cur);
        logic [31:0] r;
        r     = COMMIT;
        r[13] = ~cur;
        return r;
    endfunction

    function automatic logic [31:0] upd_word(input int i);
        return {6'(i), 5'd0, 4'h1, 3'd0, 1'b0, 13'(i)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_seen(input string tag, input int idx, input logic [31:0] exp);
        logic [31:0] obs;
        obs = (idx < seen.size()) ? seen[idx] : 32'hxxxx_xxxx;
        check(tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input logic [31:0] w);
        cmd_data  = w;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic vblank_pulse();
        vcount = 10'd480;
        hcount = 10'd0;
        step();
        vcount = 10'd0;
        hcount = 10'd1;
    endtask

    task automatic wait_pending(input string tag);
        int n = 0;
        while (frame_pending !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        check(tag, 32'(frame_pending), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_wd"},    writedata, 32'h0);
        check({tag, "_buf"},   32'(active_buf), 32'd0);
        check({tag, "_pend"},  32'(frame_pending), 32'd0);
        check({tag, "_ovf"},   32'(overflow), 32'd0);
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 32'h0;
        hcount    = 10'd1;
        vcount    = 10'd0;
        m_buf     = 1'b0;
        idle(3);
        reset = 1'b0;
        step();
        check_reset_vals("rst");

        // 1: single update, two-cycle latency, one-cycle pulse.
        cmd_data  = 32'h2822_0041;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        check("t1_lat1", writedata, 32'h0);
        step();
        check("t1_word", writedata, stamp(32'h2822_0041, m_buf));
        step();
        check("t1_gap", writedata, 32'h0);

        // 2: update, commit, update; the second update waits for the swap.
        idle(2);
        seen.delete();
        push(32'h0402_0011);
        push(COMMIT);
        push(32'h0802_2022);
        wait_pending("t2_pend");
        idle(8);
        check("t2_count_before", 32'(seen.size()), 32'd1);
        check_seen("t2_first", 0, stamp(32'h0402_0011, m_buf));
        check("t2_hold_wd", writedata, 32'h0);
        vblank_pulse();
        check("t2_swap", writedata, 32'h001E_2000);
        check("t2_buf", 32'(active_buf), 32'd1);
        check("t2_pend_clr", 32'(frame_pending), 32'd0);
        m_buf = 1'b1;
        idle(10);
        check("t2_count_after", 32'(seen.size()), 32'd3);
        check_seen("t2_third", 2, stamp(32'h0802_2022, m_buf));

        // 3: fill the FIFO while a commit waits; seventeenth push refused.
        push(COMMIT);
        wait_pending("t3_pend");
        seen.delete();
        for (int i = 0; i < 17; i++) begin
            cmd_data  = upd_word(i);
            cmd_valid = 1'b1;
            check($sformatf("t3_ready%0d", i), 32'(cmd_ready), (i < 16) ? 32'd1 : 32'd0);
            step();
        end
        cmd_valid = 1'b0;
        check("t3_ovf", 32'(overflow), 32'd1);
        vblank_pulse();
        idle(60);
        check("t3_count", 32'(seen.size()), 32'd17);
        check_seen("t3_swap", 0, swapw(m_buf));
        m_buf = ~m_buf;
        for (int i = 0; i < 16; i++)
            check_seen($sformatf("t3_word%0d", i), i + 1, stamp(upd_word(i), m_buf));
        check("t3_ovf_sticky", 32'(overflow), 32'd1);

        // 4: vblank point held for four clocks gives a single swap.
        push(COMMIT);
        wait_pending("t4_pend");
        seen.delete();
        vcount = 10'd480;
        hcount = 10'd0;
        idle(4);
        vcount = 10'd0;
        hcount = 10'd1;
        idle(10);
        check("t4_count", 32'(seen.size()), 32'd1);
        check_seen("t4_swap", 0, swapw(m_buf));
        m_buf = ~m_buf;
        check("t4_buf", 32'(active_buf), 32'(m_buf));

        // 5: reset during a pending commit with queued work discards everything.
        push(COMMIT);
        wait_pending("t5_pend");
        for (int i = 0; i < 5; i++) push(upd_word(i + 40));
        reset = 1'b1;
        step();
        check_reset_vals("t5_inrst");
        step();
        reset = 1'b0;
        m_buf = 1'b0;
        step();
        check_reset_vals("t5_after");
        seen.delete();
        vblank_pulse();
        idle(20);
        check("t5_no_words", 32'(seen.size()), 32'd0);
        check("t5_buf", 32'(active_buf), 32'd0);

        // 6: a NOP never reaches the bus and drains in one cycle.
        cmd_data  = 32'h2820_2041;
        cmd_valid = 1'b1;
        step();
        cmd_data = 32'h0C02_0005;
        step();
        cmd_valid = 1'b0;
        check("t6_nop", writedata, 32'h0);
        step();
        check("t6_next", writedata, stamp(32'h0C02_0005, m_buf));
        idle(6);
        check("t6_count", 32'(seen.size()), 32'd1);

        // Randomized batches against the ordered-word model.
        for (int b = 0; b < 20; b++) begin
            int k;
            seen.delete();
            expq.delete();
            k = int'($urandom_range(1, 10));
            for (int j = 0; j < k; j++) begin
                logic [31:0] w;
                logic [3:0]  c;
                w = $urandom;
                case ($urandom_range(0, 3))
                    0:       c = 4'h0;
                    1:       c = 4'hF;
                    default: c = 4'($urandom_range(1, 14));
                endcase
                w[20:17] = c;
                check($sformatf("r%0d_ready%0d", b, j), 32'(cmd_ready), 32'd1);
                hcount = 10'($urandom_range(1, 1023));
                vcount = 10'($urandom_range(0, 1023));
                push(w);
                if (c == 4'hF) begin
                    expq.push_back(swapw(m_buf));
                    m_buf = ~m_buf;
                end else if (c != 4'h0) begin
                    expq.push_back(stamp(w, m_buf));
                end
                idle(int'($urandom_range(0, 2)));
            end
            for (int p = 0; p < 16; p++) begin
                hcount = 10'($urandom_range(1, 1023));
                vcount = 10'($urandom_range(0, 1023));
                idle(10);
                vblank_pulse();
            end
            idle(30);
            check($sformatf("r%0d_count", b), 32'(seen.size()), 32'(expq.size()));
            for (int j = 0; j < expq.size(); j++)
                check_seen($sformatf("r%0d_w%0d", b, j), j, expq[j]);
            check($sformatf("r%0d_buf", b), 32'(active_buf), 32'(m_buf));
            check($sformatf("r%0d_pend", b), 32'(frame_pending), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
